// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the four-way traffic light controller.
//   state_t     - controller phases, ALL_RED followed by green/yellow per approach
//   LAMP_*      - one-hot lamp encodings {red,yellow,green}
//   next_phase  - fixed round-robin successor of a phase
package traffic_pkg;

   typedef enum logic [3:0] {
      ALL_RED,
      N_GRN,
      N_YEL,
      S_GRN,
      S_YEL,
      E_GRN,
      E_YEL,
      W_GRN,
      W_YEL
   } state_t;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         ALL_RED: n = N_GRN;
         N_GRN:   n = N_YEL;
         N_YEL:   n = S_GRN;
         S_GRN:   n = S_YEL;
         S_YEL:   n = E_GRN;
         E_GRN:   n = E_YEL;
         E_YEL:   n = W_GRN;
         W_GRN:   n = W_YEL;
         W_YEL:   n = N_GRN;
         default: n = ALL_RED;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/clk_divider.sv
// clk_divider: divides clk by 2*DIV_HALF into a 50% duty clk_out and emits a
// one-clk tick pulse on the clk cycle whose edge makes clk_out rise.
//   clk     in   system clock
//   rst_a   in   asynchronous active-high reset (cnt=0, clk_out=0)
//   clk_out out  divided clock
//   tick    out  1-clk pulse, high when the next clk edge raises clk_out
module clk_divider #(
   parameter int unsigned DIV_HALF = 4
) (
   input  logic clk,
   input  logic rst_a,
   output logic clk_out,
   output logic tick
);

   localparam int unsigned CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV_HALF - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_MAX) && !clk_out;

endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: four-way intersection controller granting green to
// one approach at a time in order N->S->E->W, with a yellow phase after each
// green. Phase timing is counted in rising edges of the divided clock clk_out.
//   n_lights/s_lights/e_lights/w_lights  out  registered one-hot lamps {red,yellow,green}
//   clk                                  in   system clock
//   rst_a                                in   asynchronous active-high reset
//   clk_out                              out  divided clock (period 2*DIV_HALF clk)
module traffic_light_controller
   import traffic_pkg::*;
#(
   parameter int unsigned DIV_HALF     = 4,
   parameter int unsigned GREEN_TICKS  = 6,
   parameter int unsigned YELLOW_TICKS = 2
) (
   output logic [2:0] n_lights,
   output logic [2:0] s_lights,
   output logic [2:0] e_lights,
   output logic [2:0] w_lights,
   input  logic       clk,
   input  logic       rst_a,
   output logic       clk_out
);

   localparam int unsigned MAX_TICKS = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int unsigned TW        = $clog2(MAX_TICKS + 1);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [TW-1:0] timer_last;
   logic [2:0]    n_d, s_d, e_d, w_d;
   logic          tick;

   clk_divider #(
      .DIV_HALF (DIV_HALF)
   ) u_div (
      .clk     (clk),
      .rst_a   (rst_a),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         state_q  <= ALL_RED;
         timer_q  <= '0;
         n_lights <= LAMP_RED;
         s_lights <= LAMP_RED;
         e_lights <= LAMP_RED;
         w_lights <= LAMP_RED;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         n_lights <= n_d;
         s_lights <= s_d;
         e_lights <= e_d;
         w_lights <= w_d;
      end
   end

   always_comb begin
      timer_last = '0;
      state_d    = state_q;
      timer_d    = timer_q;
      n_d        = LAMP_RED;
      s_d        = LAMP_RED;
      e_d        = LAMP_RED;
      w_d        = LAMP_RED;

      case (state_q)
         N_GRN, S_GRN, E_GRN, W_GRN: timer_last = TW'(GREEN_TICKS - 1);
         N_YEL, S_YEL, E_YEL, W_YEL: timer_last = TW'(YELLOW_TICKS - 1);
         default:                    timer_last = '0;
      endcase

      if (tick) begin
         if (timer_q == timer_last) begin
            state_d = next_phase(state_q);
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end

      // Lamps are decoded from the next state so they register on the same edge
      // as the state itself.
      case (state_d)
         N_GRN:   n_d = LAMP_GRN;
         N_YEL:   n_d = LAMP_YEL;
         S_GRN:   s_d = LAMP_GRN;
         S_YEL:   s_d = LAMP_YEL;
         E_GRN:   e_d = LAMP_GRN;
         E_YEL:   e_d = LAMP_YEL;
         W_GRN:   w_d = LAMP_GRN;
         W_YEL:   w_d = LAMP_YEL;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_light_controller.sv
`timescale 1ns/1ps
module tb_traffic_light_controller;

   localparam int DIV  = 4;
   localparam int GT   = 6;
   localparam int YT   = 2;
   localparam int PH   = GT + YT;
   localparam int ROT  = 4 * PH;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1;
   logic [2:0] n_lights, s_lights, e_lights, w_lights;
   logic       clk_out;

   int n_checks = 0;
   int n_pass   = 0;
   int n_edges  = 0;
   bit run_chk  = 1'b0;
   logic [2:0] prev [4];

   traffic_light_controller #(
      .DIV_HALF     (DIV),
      .GREEN_TICKS  (GT),
      .YELLOW_TICKS (YT)
   ) dut (
      .n_lights (n_lights),
      .s_lights (s_lights),
      .e_lights (e_lights),
      .w_lights (w_lights),
      .clk      (clk),
      .rst_a    (rst_a),
      .clk_out  (clk_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Model: everything follows from the clk edges seen since reset release.
   function automatic int ticks_at(input int n);
      return (n + DIV) / (2 * DIV);
   endfunction

   function automatic logic exp_clk(input int n);
      return logic'((n / DIV) % 2);
   endfunction

   function automatic logic [2:0] exp_lamp(input int k, input int dir);
      int p;
      if (k == 0) return RED;
      p = (k - 1) % ROT;
      if (p / PH != dir) return RED;
      return ((p % PH) < GT) ? GRN : YEL;
   endfunction

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) n_edges <= 0;
      else       n_edges <= n_edges + 1;
   end

   always @(negedge clk) begin
      if (run_chk && !rst_a) begin
         logic [2:0] cur [4];
         int k, nonred;
         cur[0] = n_lights; cur[1] = s_lights; cur[2] = e_lights; cur[3] = w_lights;
         k = ticks_at(n_edges);
         check("clk_out", 32'(clk_out), 32'(exp_clk(n_edges)));
         check("n_lights", 32'(cur[0]), 32'(exp_lamp(k, 0)));
         check("s_lights", 32'(cur[1]), 32'(exp_lamp(k, 1)));
         check("e_lights", 32'(cur[2]), 32'(exp_lamp(k, 2)));
         check("w_lights", 32'(cur[3]), 32'(exp_lamp(k, 3)));
         nonred = 0;
         for (int d = 0; d < 4; d++) begin
            if (cur[d] != RED) nonred++;
            check("lamp_legal", 32'(cur[d] == RED || cur[d] == YEL || cur[d] == GRN), 32'd1);
            if (prev[d] == GRN)
               check("grn_to_yel", 32'(cur[d] == GRN || cur[d] == YEL), 32'd1);
            prev[d] = cur[d];
         end
         check("one_active", 32'(nonred <= 1), 32'd1);
      end
      if (rst_a) for (int d = 0; d < 4; d++) prev[d] = RED;
   end

   task automatic async_reset_check(input string tag);
      @(posedge clk);
      #($urandom_range(1, 4));
      rst_a = 1'b1;
      #1;
      check({tag, "_n"},   32'(n_lights), 32'(RED));
      check({tag, "_s"},   32'(s_lights), 32'(RED));
      check({tag, "_e"},   32'(e_lights), 32'(RED));
      check({tag, "_w"},   32'(w_lights), 32'(RED));
      check({tag, "_clk"}, 32'(clk_out),  32'd0);
   endtask

   task automatic release_reset();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      rst_a = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 4; d++) prev[d] = RED;
      repeat (3) @(negedge clk);
      check("por_n", 32'(n_lights), 32'(RED));
      check("por_clk", 32'(clk_out), 32'd0);
      run_chk = 1'b1;
      release_reset();

      // 50 ticks end at edge 396; cover full rotation wrap.
      repeat (400) @(negedge clk);

      // Reset while east is yellow (ticks 23..24, edges 180..195).
      async_reset_check("rst_run");
      release_reset();
      repeat (180 + $urandom_range(0, 6)) @(negedge clk);
      check("pre_rst_e_yel", 32'(e_lights), 32'(YEL));
      async_reset_check("rst_e_yel");
      release_reset();

      // Randomly timed resets and run lengths.
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(1, 300)) @(negedge clk);
         async_reset_check("rst_rand");
         release_reset();
      end
      repeat (40) @(negedge clk);

      run_chk = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
